// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control: in-flight scoreboard, load-use stall, redirect flush, multi-cycle EX hold.
// Build macro PIPE_FWD_EN enables EX forwarding; without it any RAW match in entries 0..DEPTH-2 stalls ID.
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int RA_W       = 5,
  parameter int LOAD_STAGE = 2,
  parameter int MUL_CYCLES = 4,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_wr_addr,
  input  logic             id_is_load,
  input  logic             id_multi,
  input  logic             ex_redirect,
  output logic             stall_if,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             hold_id_ex,
  output logic             bubble_ex_mem,
  output logic             ex_start,
  output logic             busy,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef struct packed {
    logic            vld;
    logic            wr_en;
    logic [RA_W-1:0] addr;
    logic            is_load;
    logic            multi;
  } prod_t;

  prod_t            ent_q [DEPTH];
  prod_t            ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_start_q, ex_start_d;

  logic raw_hit, load_use, found_rs, found_rt;
  logic hazard, busy_hold, redir_eff, issue;

  function automatic logic src_match(input prod_t e, input logic [RA_W-1:0] src, input logic use_src);
    return e.vld && e.wr_en && (e.addr == src) && (src != '0) && use_src;
  endfunction

  // Only the nearest producer of each source decides whether it is a blocking load.
  always_comb begin
    raw_hit  = 1'b0;
    load_use = 1'b0;
    found_rs = 1'b0;
    found_rt = 1'b0;
    for (int j = 0; j < DEPTH-1; j++) begin
      if (!found_rs && src_match(ent_q[j], id_rs, id_use_rs)) begin
        found_rs = 1'b1;
        raw_hit  = 1'b1;
        if (ent_q[j].is_load && ((j + 1) < LOAD_STAGE)) load_use = 1'b1;
      end
      if (!found_rt && src_match(ent_q[j], id_rt, id_use_rt)) begin
        found_rt = 1'b1;
        raw_hit  = 1'b1;
        if (ent_q[j].is_load && ((j + 1) < LOAD_STAGE)) load_use = 1'b1;
      end
    end
  end

`ifdef PIPE_FWD_EN
  assign hazard = id_valid && load_use;
`else
  assign hazard = id_valid && (raw_hit || load_use);
`endif

  assign busy_hold = (cnt_q != '0);
  assign redir_eff = ex_redirect && !busy_hold;
  assign issue     = id_valid && !hazard && !redir_eff && !busy_hold;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) ent_d[j] = ent_q[j];
    cnt_d      = cnt_q;
    ex_start_d = 1'b0;
    if (busy_hold) begin
      // EX keeps the multi-cycle op; EX/MEM sees bubbles while older entries drain.
      cnt_d    = cnt_q - CNT_W'(1);
      ent_d[1] = '0;
      for (int j = 2; j < DEPTH; j++) ent_d[j] = ent_q[j-1];
    end else begin
      ent_d[0] = '0;
      if (issue) begin
        ent_d[0].vld     = 1'b1;
        ent_d[0].wr_en   = id_wr_en;
        ent_d[0].addr    = id_wr_addr;
        ent_d[0].is_load = id_is_load;
        ent_d[0].multi   = id_multi;
      end
      for (int j = 1; j < DEPTH; j++) ent_d[j] = ent_q[j-1];
      if (issue && id_multi) begin
        cnt_d      = CNT_W'(MUL_CYCLES - 1);
        ex_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
      cnt_q      <= '0;
      ex_start_q <= 1'b0;
    end else begin
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
      cnt_q      <= cnt_d;
      ex_start_q <= ex_start_d;
    end
  end

  assign stall_if      = !reset && (busy_hold || (hazard && !redir_eff));
  assign flush_if_id   = !reset && redir_eff;
  assign bubble_id_ex  = !reset && !busy_hold && (redir_eff || hazard);
  assign hold_id_ex    = !reset && busy_hold;
  assign bubble_ex_mem = !reset && busy_hold;
  assign ex_start      = !reset && ex_start_q;
  assign busy          = !reset && ent_q[0].vld && ent_q[0].multi;

`ifdef PIPE_FWD_EN
  typedef struct packed {
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
  } src_t;

  src_t             src_q, src_d;
  logic [SEL_W-1:0] fwd_a, fwd_b;

  // Source operands of the ID/EX occupant, tracked alongside entry 0.
  always_comb begin
    src_d = src_q;
    if (!busy_hold) begin
      src_d = '0;
      if (issue) begin
        src_d.rs     = id_rs;
        src_d.rt     = id_rt;
        src_d.use_rs = id_use_rs;
        src_d.use_rt = id_use_rt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_q <= '0;
    else       src_q <= src_d;
  end

  // Scanning oldest to youngest lets the youngest matching producer win.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int j = DEPTH-1; j >= 1; j--) begin
      if (src_match(ent_q[j], src_q.rs, src_q.use_rs)) fwd_a = SEL_W'(j);
      if (src_match(ent_q[j], src_q.rt, src_q.use_rt)) fwd_b = SEL_W'(j);
    end
  end

  assign fwd_sel_a = reset ? '0 : fwd_a;
  assign fwd_sel_b = reset ? '0 : fwd_b;
`else
  assign fwd_sel_a = '0;
  assign fwd_sel_b = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queued scoreboard and a negedge monitor.
// Expected outputs per cycle are hand-derived for the default parameters, both PIPE_FWD_EN builds.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_multi, ex_redirect;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       stall_if, flush_if_id, bubble_id_ex, hold_id_ex, bubble_ex_mem, ex_start, busy;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  // Expected vector layout: {st, fl, bu, ho, bm, es, bs, fa[1:0], fb[1:0]}
  localparam logic [10:0] O0    = 11'b0;
  localparam logic [10:0] STL   = {1'b1, 1'b0, 1'b1, 8'b0};
  localparam logic [10:0] FLU   = {1'b0, 1'b1, 1'b1, 8'b0};
  localparam logic [10:0] HOLD1 = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0};
  localparam logic [10:0] HOLD  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0};
  localparam logic [10:0] BSY   = {6'b0, 1'b1, 4'b0};

  logic [10:0] exp_q [$];
  int          row_q [$];
  int          row_n  = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_wr_en      (id_wr_en),
    .id_wr_addr    (id_wr_addr),
    .id_is_load    (id_is_load),
    .id_multi      (id_multi),
    .ex_redirect   (ex_redirect),
    .stall_if      (stall_if),
    .flush_if_id   (flush_if_id),
    .bubble_id_ex  (bubble_id_ex),
    .hold_id_ex    (hold_id_ex),
    .bubble_ex_mem (bubble_ex_mem),
    .ex_start      (ex_start),
    .busy          (busy),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b)
  );

  function automatic logic [10:0] fw(input logic [1:0] a, input logic [1:0] b);
    return {7'b0, a, b};
  endfunction

  task automatic cyc(input logic v, input int wa, input int rs, input int rt,
                     input logic urs, input logic urt, input logic ld, input logic mul,
                     input logic rd, input logic [10:0] ex);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_wr_en    = v && (wa != 0);
    id_wr_addr  = 5'(wa);
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_is_load  = ld;
    id_multi    = mul;
    ex_redirect = rd;
    exp_q.push_back(ex);
    row_q.push_back(row_n);
    row_n++;
  endtask

  task automatic i_nop(input logic [10:0] ex);
    cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex);
  endtask
  task automatic i_alu(input int wa, input int rs, input int rt, input logic rd, input logic [10:0] ex);
    cyc(1'b1, wa, rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, rd, ex);
  endtask
  task automatic i_lw(input int wa, input int rs, input logic [10:0] ex);
    cyc(1'b1, wa, rs, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex);
  endtask
  task automatic i_mul(input int wa, input int rs, input int rt, input logic [10:0] ex);
    cyc(1'b1, wa, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ex);
  endtask

  always @(negedge clk) begin : monitor
    logic [10:0] got, want;
    int          r;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      r    = row_q.pop_front();
      got  = {stall_if, flush_if_id, bubble_id_ex, hold_id_ex, bubble_ex_mem,
              ex_start, busy, fwd_sel_a, fwd_sel_b};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL row %0d outputs: got %b want %b (st fl bu ho bm es bs fa fb)", r, got, want);
      end
    end
  end

  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0; id_rs = '0; id_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_load = 1'b0; id_multi = 1'b0; ex_redirect = 1'b0;

    // Reset: outputs stay low even with a redirect and a valid ID instruction present.
    i_alu(3, 1, 2, 1'b1, O0);
    i_nop(O0);
    reset = 1'b0;
    i_nop(O0);

    // add r3,r1,r2 ; sub r4,r3,r5
`ifdef PIPE_FWD_EN
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(4, 3, 5, 1'b0, O0);
    i_nop(fw(2'd1, 2'd0));
    i_nop(O0);
`else
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(4, 3, 5, 1'b0, STL);
    i_alu(4, 3, 5, 1'b0, STL);
    i_alu(4, 3, 5, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);
`endif

    // add r3 ; nop ; or r6,r3,r0
`ifdef PIPE_FWD_EN
    i_alu(3, 1, 2, 1'b0, O0);
    i_nop(O0);
    i_alu(6, 3, 0, 1'b0, O0);
    i_nop(fw(2'd2, 2'd0));
    i_nop(O0);
`else
    i_alu(3, 1, 2, 1'b0, O0);
    i_nop(O0);
    i_alu(6, 3, 0, 1'b0, STL);
    i_alu(6, 3, 0, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);
`endif

    // lw r3 ; add r4,r3,r3
`ifdef PIPE_FWD_EN
    i_lw(3, 1, O0);
    i_alu(4, 3, 3, 1'b0, STL);
    i_alu(4, 3, 3, 1'b0, O0);
    i_nop(fw(2'd2, 2'd2));
    i_nop(O0);
`else
    i_lw(3, 1, O0);
    i_alu(4, 3, 3, 1'b0, STL);
    i_alu(4, 3, 3, 1'b0, STL);
    i_alu(4, 3, 3, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);
`endif

    // lw r3 ; add r4,r3,r1 with a redirect in the stall cycle
    i_lw(3, 1, O0);
    i_alu(4, 3, 1, 1'b1, FLU);
    i_nop(O0);
    i_nop(O0);
    i_nop(O0);

    // Producer already in the last latch: no stall, no forward.
    i_alu(3, 1, 2, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);
    i_alu(4, 3, 5, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);

    // Two producers of r3: the younger one forwards.
`ifdef PIPE_FWD_EN
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(5, 3, 3, 1'b0, O0);
    i_nop(fw(2'd1, 2'd1));
    i_nop(O0);
    i_nop(O0);
`else
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(3, 1, 2, 1'b0, O0);
    i_alu(5, 3, 3, 1'b0, STL);
    i_alu(5, 3, 3, 1'b0, STL);
    i_alu(5, 3, 3, 1'b0, O0);
    i_nop(O0);
    i_nop(O0);
`endif

    // Multi-cycle op; redirect during a hold cycle is ignored.
    i_mul(7, 1, 2, O0);
    i_alu(8, 9, 10, 1'b0, HOLD1);
    i_alu(8, 9, 10, 1'b1, HOLD);
    i_alu(8, 9, 10, 1'b0, HOLD);
    i_alu(8, 9, 10, 1'b0, BSY);
    i_nop(O0);
    i_nop(O0);
    i_nop(O0);

    // Reset asserted in hold cycle 2 clears outputs at once and aborts the op.
    i_mul(7, 1, 2, O0);
    i_alu(8, 9, 10, 1'b0, HOLD1);
    i_alu(8, 9, 10, 1'b0, O0);
    reset = 1'b1;
    i_alu(8, 9, 10, 1'b0, O0);
    reset = 1'b0;
    i_nop(O0);
    i_nop(O0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
